// File: rtl/alu_logic_pipe.sv
// Pipelined bitwise/reduction logic unit with valid/ready on both sides.
// Ports: clk, rst_n; in_valid/in_ready/op/a/b in; out_valid/out_ready/result/zero/parity out.
module alu_logic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("alu_logic_pipe: STAGES must be 1..4");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("alu_logic_pipe: WIDTH must be >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] ab;
    logic [CW-1:0]    popc;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        ab   = a & b;
        popc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popc = popc + CW'(ab[i]);
        end
        res_d = '0;
        case (op)
            3'b000: res_d = ab;
            3'b001: res_d = a | b;
            3'b010: res_d = a ^ b;
            3'b011: res_d = ~(a | b);
            3'b100: res_d = a & ~b;
            3'b101: res_d = a | ~b;
            3'b110: res_d = a;
            3'b111: res_d = WIDTH'(popc);
        endcase
    end

    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  res_q  [STAGES];
    logic              zero_q [STAGES];
    logic              par_q  [STAGES];

    // rdy[k]: stage k may load this cycle (empty, or its content moves on).
    logic [STAGES-1:0] rdy;
    logic              chain;

    always_comb begin
        chain = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = ~vld_q[k] | chain;
            chain  = rdy[k];
        end
    end

    assign in_ready = rdy[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k]  <= '0;
                zero_q[k] <= 1'b0;
                par_q[k]  <= 1'b0;
            end
        end else begin
            if (rdy[0]) begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    res_q[0]  <= res_d;
                    zero_q[0] <= (res_d == '0);
                    par_q[0]  <= ^res_d;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    // Empty slots keep stale data; only valid bits matter.
                    if (vld_q[k-1]) begin
                        res_q[k]  <= res_q[k-1];
                        zero_q[k] <= zero_q[k-1];
                        par_q[k]  <= par_q[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
    assign parity    = par_q[STAGES-1];

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Directed bench for alu_logic_pipe: WIDTH=32/STAGES=2 plus
// WIDTH=8 with STAGES=1 and STAGES=4, one instance active at a time.
module tb_alu_logic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v;
    logic        ordy;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cur_st;
    int          total;
    int          bad;

    logic ir2, ov2, z2, p2;
    logic [31:0] r2;
    logic ir1, ov1, z1, p1;
    logic [7:0] r1;
    logic ir4, ov4, z4, p4;
    logic [7:0] r4;

    logic ir, ov, z, p;
    logic [31:0] r;

    alu_logic_pipe #(.WIDTH(32), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v && cur_st == 2), .in_ready(ir2),
        .op(op), .a(a), .b(b),
        .out_valid(ov2), .out_ready(ordy && cur_st == 2),
        .result(r2), .zero(z2), .parity(p2)
    );

    alu_logic_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v && cur_st == 1), .in_ready(ir1),
        .op(op), .a(a[7:0]), .b(b[7:0]),
        .out_valid(ov1), .out_ready(ordy && cur_st == 1),
        .result(r1), .zero(z1), .parity(p1)
    );

    alu_logic_pipe #(.WIDTH(8), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v && cur_st == 4), .in_ready(ir4),
        .op(op), .a(a[7:0]), .b(b[7:0]),
        .out_valid(ov4), .out_ready(ordy && cur_st == 4),
        .result(r4), .zero(z4), .parity(p4)
    );

    always_comb begin
        ir = ir2; ov = ov2; z = z2; p = p2; r = r2;
        case (cur_st)
            1: begin ir = ir1; ov = ov1; z = z1; p = p1; r = {24'h0, r1}; end
            4: begin ir = ir4; ov = ov4; z = z4; p = p4; r = {24'h0, r4}; end
            default: ;
        endcase
    end

    function automatic logic [31:0] msk();
        return (cur_st == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] m);
        logic [31:0] xm, ym, res;
        int c;
        xm = x & m;
        ym = y & m;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(xm[i] & ym[i]);
        case (o)
            3'd0: res = xm & ym;
            3'd1: res = xm | ym;
            3'd2: res = xm ^ ym;
            3'd3: res = ~(xm | ym);
            3'd4: res = xm & ~ym;
            3'd5: res = xm | ~ym;
            3'd6: res = xm;
            default: res = 32'(c);
        endcase
        return res & m;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; v = 1'b0; ordy = 1'b0;
        op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", ov); end
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_result got=%h want=0", r); end
        total++; if (z !== 1'b0) begin bad++; $display("FAIL rst_zero got=%b want=0", z); end
        total++; if (p !== 1'b0) begin bad++; $display("FAIL rst_parity got=%b want=0", p); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ir !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", ir); end
    endtask

    task automatic test_single(input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] er,
                               input logic ez, input logic ep);
        int cyc;
        @(negedge clk);
        op = o; a = x; b = y; v = 1'b1; ordy = 1'b1;
        total++; if (ir !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b want=1", ir); end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            v = 1'b0;
        end while (!ov && cyc < 20);
        total++; if (cyc !== cur_st) begin bad++; $display("FAIL latency st=%0d got=%0d want=%0d", cur_st, cyc, cur_st); end
        total++; if (r !== er) begin bad++; $display("FAIL single_result op=%0d got=%h want=%h", o, r, er); end
        total++; if (z !== ez) begin bad++; $display("FAIL single_zero op=%0d got=%b want=%b", o, z, ez); end
        total++; if (p !== ep) begin bad++; $display("FAIL single_parity op=%0d got=%b want=%b", o, p, ep); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e [8];
        int got, first, last;
        for (int i = 0; i < 8; i++) e[i] = model(3'(i), 32'hC3A5_96F0, 32'h0FF0_55AA, msk());
        got = 0; first = 0; last = 0;
        ordy = 1'b1;
        for (int cyc = 0; cyc < 8 + cur_st + 4; cyc++) begin
            @(negedge clk);
            if (ov) begin
                total++;
                if (got >= 8) begin
                    bad++; $display("FAIL b2b_extra got=%0d want=8", got + 1);
                end else if (r !== e[got]) begin
                    bad++; $display("FAIL b2b_result idx=%0d got=%h want=%h", got, r, e[got]);
                end
                if (got == 0) first = cyc;
                last = cyc;
                got++;
            end
            if (cyc < 8) begin
                v = 1'b1; op = 3'(cyc); a = 32'hC3A5_96F0; b = 32'h0FF0_55AA;
                total++; if (ir !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, ir); end
            end else begin
                v = 1'b0;
            end
        end
        total++; if (got !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
        total++; if (last - first !== 7) begin bad++; $display("FAIL b2b_spacing got=%0d want=7", last - first); end
    endtask

    task automatic test_stall();
        logic [31:0] e [6];
        logic [31:0] hr;
        logic hz, hp, held;
        int acc, got;
        for (int i = 0; i < 6; i++) e[i] = model(3'(i), 32'h3C3C_A5A5, 32'h0F0F_F00F, msk());
        acc = 0; held = 1'b0; hr = '0; hz = 1'b0; hp = 1'b0;
        ordy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ov) begin
                if (!held) begin
                    held = 1'b1; hr = r; hz = z; hp = p;
                end else begin
                    total++;
                    if (r !== hr || z !== hz || p !== hp) begin
                        bad++; $display("FAIL stall_hold got=%h want=%h", r, hr);
                    end
                end
            end
            v = 1'b1; op = 3'(acc); a = 32'h3C3C_A5A5; b = 32'h0F0F_F00F;
            if (ir) acc++;
        end
        total++; if (acc !== cur_st) begin bad++; $display("FAIL stall_accepted got=%0d want=%0d", acc, cur_st); end
        total++; if (ir !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", ir); end
        total++; if (hr !== e[0]) begin bad++; $display("FAIL stall_head got=%h want=%h", hr, e[0]); end
        v = 1'b0; ordy = 1'b1; got = 0;
        for (int c = 0; c < cur_st + 6; c++) begin
            if (ov) begin
                total++;
                if (got >= acc) begin
                    bad++; $display("FAIL drain_extra got=%0d want=%0d", got + 1, acc);
                end else if (r !== e[got]) begin
                    bad++; $display("FAIL drain_result idx=%0d got=%h want=%h", got, r, e[got]);
                end
                got++;
            end
            @(negedge clk);
        end
        total++; if (got !== acc) begin bad++; $display("FAIL drain_count got=%0d want=%0d", got, acc); end
    endtask

    task automatic test_reset_midstall();
        ordy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            v = 1'b1; op = 3'(c + 1); a = 32'h1234_5678; b = 32'h8765_4321;
        end
        @(negedge clk);
        v = 1'b0;
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL midstall_full got=%b want=1", ov); end
        rst_n = 1'b0;
        #1;
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", ov); end
        total++; if (r !== 32'h0) begin bad++; $display("FAIL midrst_result got=%h want=0", r); end
        total++; if (z !== 1'b0 || p !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b%b want=00", z, p); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ir !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", ir); end
        test_single(3'b010, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0; cur_st = 2;
        v = 1'b0; ordy = 1'b0; op = '0; a = '0; b = '0; rst_n = 1'b0;
        test_reset();
        test_single(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
        test_single(3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        test_single(3'b111, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_0008, 1'b0, 1'b1);
        test_back_to_back();
        test_stall();
        test_reset_midstall();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            v = 1'b0;
            cur_st = (s == 0) ? 1 : 4;
            test_single(3'b101, 32'h0000_000F, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0);
            test_back_to_back();
            test_stall();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
